debug_host_link: RTL and testbench
==================================

# debug_host_link

Host-side end of the debug UART link. It is the initiator counterpart of the on-chip debug unit: it serialises command frames (an opcode byte plus an optional 32-bit payload) onto the UART line. It then collects the 32-bit response words the debug unit sends back (latch snapshots, PC, register-file and memory data). It is used as the FPGA-side bridge on a host board and as a bus-functional driver in system benches.

## Interface
Parameters:
- CLKS_PER_BIT, default 10417: clock cycles per UART bit (100 MHz / 9600 baud).
- TIMEOUT_CYCLES, default 2_000_000: maximum idle gap allowed between response bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_op  in  8  opcode byte; bit 7 set means a 32-bit payload follows
- cmd_data  in  32  payload, sent LSB byte first
- cmd_rsp_words  in  6  number of 32-bit response words expected, 0..63
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  32  assembled response word
- rsp_last  out  1  qualifies rsp_valid; marks the final word
- done  out  1  one-cycle pulse, transaction complete
- timeout  out  1  one-cycle pulse, response gap exceeded
- frame_err  out  1  one-cycle pulse, received stop bit was 0
- busy  out  1  transaction in progress
- TX  out  1  UART line to the debug unit's RX, idles high
- RX  in  1  UART line from the debug unit's TX, asynchronous

## Operation
- UART format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1.
- FSM states and transitions:
  - IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready; latch op, data and word count.
  - SEND_OP: transmit the opcode byte.
    - If op[7]=1, go to SEND_DATA.
    - Else if count>0, go to RECV.
    - Else go to DONE.
  - SEND_DATA: transmit 4 bytes, data[7:0] first.
    - If count>0, go to RECV; else go to DONE.
  - RECV: assemble bytes LSB first into a 32-bit shift register.
    - On every 4th byte, pulse rsp_valid and decrement the count.
    - When the count reaches 0, assert rsp_last with that rsp_valid, then go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Timeout: the gap counter clears on entry to RECV and on each received byte. At TIMEOUT_CYCLES, pulse timeout (no done pulse) and return to IDLE. A partially assembled word is discarded.
- Receiver:
  - 2-flop synchroniser on RX; falling edge starts a frame.
  - Start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the frame is abandoned as a glitch.
  - Data bits are then sampled every CLKS_PER_BIT.
  - If the stop bit samples 0: pulse frame_err, drop the byte, do not clear the gap counter.
  - The receiver runs in every state; bytes completed outside RECV are discarded.
- rsp_data holds its value until the next rsp_valid. There is no backpressure; the consumer must take each word on the pulse.
- busy = !cmd_ready.

## Timing
- Reset values: TX=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_last=0, done=0, timeout=0, frame_err=0, rsp_data=0. FSM in IDLE, all counters 0.
- Command accepted at edge N: TX drives the start bit from edge N+1.
- Each byte occupies exactly 10*CLKS_PER_BIT cycles. Consecutive bytes are back-to-back with no idle bits.
- Transaction with rsp_words=0: done pulses 1 cycle after the last stop bit completes, and cmd_ready is high the cycle after that.
- Response data: rsp_valid rises 1 cycle after the stop-bit sample of the 4th byte of each word. done pulses on the following cycle.
- cmd_valid while busy is ignored; there is no queuing.
- rst asserted mid-transaction: takes effect at the next edge regardless of state.
  - TX returns high, a truncated frame is acceptable.
  - The receiver returns to hunting for a start bit.
  - No done or timeout pulse is generated.
- Response bytes arriving while still in SEND_*: discarded; only bytes completed in RECV count.

## Structure
- Shared debug package holds:
  - opcode constants, shared with the debug unit;
  - the payload-flag bit index (7);
  - the FSM state enum, 3-bit encoding;
  - the default CLKS_PER_BIT.
- One sub-module, debug_uart_phy: bit-timing counter, TX serialiser (start/ready/busy), RX synchroniser and deserialiser (byte_valid/byte/frame_err).
- debug_host_link itself holds the FSM, byte/word counters, word assembler and timeout counter.

## Test plan
Bench parameters: CLKS_PER_BIT=4, TIMEOUT_CYCLES=200, with an RX model of the debug unit.

1. rst held for 3 cycles -> all outputs at their reset values, TX=1 throughout.
2. op=0x05, rsp_words=0 -> TX carries one frame with bits 0,1,0,1,0,0,0,0,0,1 over 40 cycles; done pulses at cycle 41 after accept.
3. op=0x81, data=0xDEADBEEF, rsp_words=0 -> TX bytes in order 0x81, EF, BE, AD, DE over 200 cycles, then done.
4. op=0x02, rsp_words=2; model replies with bytes 78 56 34 12 F0 DE BC 9A:
   - rsp_data=0x12345678 with rsp_last=0;
   - then rsp_data=0x9ABCDEF0 with rsp_last=1;
   - then done.
5. rsp_words=1; model sends 2 bytes then goes silent -> timeout pulses 200 cycles after the 2nd byte; no rsp_valid; cmd_ready=1 on the next cycle.
6. Reply byte with stop bit forced 0 -> frame_err pulses and the byte is not counted. Separately, rst asserted mid-payload -> TX=1 the next cycle, cmd_ready=1, and a new command is accepted immediately after.

Source files
------------

// File: rtl/debug_host_link_pkg.sv
// Shared definitions for the debug UART link: opcodes, payload flag,
// host-link FSM states and default bit timing.
package debug_host_link_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10417;
    localparam int unsigned PAYLOAD_BIT          = 7;

    // Opcodes understood by the on-chip debug unit; bit 7 flags a 32-bit payload.
    localparam logic [7:0] OP_READ_LATCH = 8'h01;
    localparam logic [7:0] OP_READ_PC    = 8'h02;
    localparam logic [7:0] OP_READ_REGS  = 8'h03;
    localparam logic [7:0] OP_HALT       = 8'h04;
    localparam logic [7:0] OP_STEP       = 8'h05;
    localparam logic [7:0] OP_RESUME     = 8'h06;
    localparam logic [7:0] OP_SET_BREAK  = 8'h81;
    localparam logic [7:0] OP_READ_MEM   = 8'h82;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_OP   = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_RECV      = 3'd3,
        ST_DONE      = 3'd4
    } linkState_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rxState_t;

    function automatic logic hasPayload(input logic [7:0] op);
        return op[PAYLOAD_BIT];
    endfunction

endpackage

// File: rtl/debug_uart_phy.sv
// 8N1 UART bit engine for the debug link: TX serialiser and a synchronised
// RX deserialiser sharing the same CLKS_PER_BIT timing.
module debug_uart_phy
    import debug_host_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txStart,
    input  logic [7:0] txByte,
    output logic       txReady,
    output logic       txBusy,
    output logic       txLine,
    input  logic       rxLine,
    output logic       rxByteValid,
    output logic [7:0] rxByte,
    output logic       rxFrameErr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

    logic [CW-1:0] txClk;
    logic [3:0]    txBit;
    logic [8:0]    txShift;
    logic          txLastTick;

    // Ready in the final stop-bit cycle too, so frames can run back-to-back.
    assign txLastTick = txBusy && (txBit == 4'd9) && (txClk == BIT_LAST);
    assign txReady    = !txBusy || txLastTick;

    always_ff @(posedge clk) begin
        if (rst) begin
            txLine  <= 1'b1;
            txBusy  <= 1'b0;
            txClk   <= '0;
            txBit   <= '0;
            txShift <= '1;
        end else if (txStart && txReady) begin
            txLine  <= 1'b0;
            txShift <= {1'b1, txByte};
            txBit   <= '0;
            txClk   <= '0;
            txBusy  <= 1'b1;
        end else if (txBusy) begin
            if (txClk == BIT_LAST) begin
                txClk <= '0;
                if (txBit == 4'd9) begin
                    txBusy <= 1'b0;
                    txLine <= 1'b1;
                end else begin
                    txLine  <= txShift[0];
                    txShift <= {1'b1, txShift[8:1]};
                    txBit   <= txBit + 4'd1;
                end
            end else begin
                txClk <= txClk + 1'b1;
            end
        end
    end

    logic          rxMeta;
    logic          rxSync;
    logic          rxPrev;
    rxState_t      rxState;
    logic [CW-1:0] rxClk;
    logic [2:0]    rxBit;
    logic [7:0]    rxShift;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta      <= 1'b1;
            rxSync      <= 1'b1;
            rxPrev      <= 1'b1;
            rxState     <= RX_IDLE;
            rxClk       <= '0;
            rxBit       <= '0;
            rxShift     <= '0;
            rxByte      <= '0;
            rxByteValid <= 1'b0;
            rxFrameErr  <= 1'b0;
        end else begin
            rxMeta      <= rxLine;
            rxSync      <= rxMeta;
            rxPrev      <= rxSync;
            rxByteValid <= 1'b0;
            rxFrameErr  <= 1'b0;
            unique case (rxState)
                RX_IDLE: begin
                    if (rxPrev && !rxSync) begin
                        rxState <= RX_START;
                        rxClk   <= '0;
                    end
                end
                RX_START: begin
                    // Mid-bit recheck rejects short glitches on the line.
                    if (rxClk == HALF_LAST) begin
                        rxClk   <= '0;
                        rxBit   <= '0;
                        rxState <= rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        rxClk <= rxClk + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rxClk == BIT_LAST) begin
                        rxClk   <= '0;
                        rxShift <= {rxSync, rxShift[7:1]};
                        if (rxBit == 3'd7) begin
                            rxState <= RX_STOP;
                        end else begin
                            rxBit <= rxBit + 3'd1;
                        end
                    end else begin
                        rxClk <= rxClk + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rxClk == BIT_LAST) begin
                        rxClk   <= '0;
                        rxState <= RX_IDLE;
                        if (rxSync) begin
                            rxByteValid <= 1'b1;
                            rxByte      <= rxShift;
                        end else begin
                            rxFrameErr <= 1'b1;
                        end
                    end else begin
                        rxClk <= rxClk + 1'b1;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_host_link.sv
// Host-side initiator of the debug UART link: sends opcode/payload frames and
// collects the 32-bit response words returned by the debug unit.
module debug_host_link
    import debug_host_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic [5:0]  cmd_rsp_words,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        done,
    output logic        timeout,
    output logic        frame_err,
    output logic        busy,
    output logic        TX,
    input  logic        RX
);

    localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

    linkState_t  state;
    linkState_t  nextState;
    logic [7:0]  opReg;
    logic [31:0] dataReg;
    logic [5:0]  wordsLeft;
    logic [2:0]  byteCnt;
    logic [23:0] wordShift;
    logic [GW-1:0] gapCnt;

    logic       txStart;
    logic [7:0] txByte;
    logic [7:0] dataByte;
    logic       txReady;
    logic       txBusy;
    logic       frameEnd;
    logic       rxByteValid;
    logic [7:0] rxByte;

    debug_uart_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uPhy (
        .clk         (clk),
        .rst         (rst),
        .txStart     (txStart),
        .txByte      (txByte),
        .txReady     (txReady),
        .txBusy      (txBusy),
        .txLine      (TX),
        .rxLine      (RX),
        .rxByteValid (rxByteValid),
        .rxByte      (rxByte),
        .rxFrameErr  (frame_err)
    );

    assign frameEnd  = txBusy && txReady;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = !cmd_ready;

    always_comb begin
        unique case (byteCnt[1:0])
            2'd1:    dataByte = dataReg[15:8];
            2'd2:    dataByte = dataReg[23:16];
            2'd3:    dataByte = dataReg[31:24];
            default: dataByte = dataReg[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // byteCnt counts frames handed to the PHY while sending, bytes of the
    // current word while receiving.
    always_comb begin
        nextState = state;
        txStart   = 1'b0;
        txByte    = opReg;
        done      = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) nextState = ST_SEND_OP;
            end
            ST_SEND_OP: begin
                if (byteCnt == 3'd0) begin
                    txStart = !txBusy;
                end else if (frameEnd) begin
                    if (hasPayload(opReg)) begin
                        txStart   = 1'b1;
                        txByte    = dataReg[7:0];
                        nextState = ST_SEND_DATA;
                    end else begin
                        nextState = (wordsLeft != 6'd0) ? ST_RECV : ST_DONE;
                    end
                end
            end
            ST_SEND_DATA: begin
                if (frameEnd) begin
                    if (byteCnt != 3'd4) begin
                        txStart = 1'b1;
                        txByte  = dataByte;
                    end else begin
                        nextState = (wordsLeft != 6'd0) ? ST_RECV : ST_DONE;
                    end
                end
            end
            ST_RECV: begin
                if (wordsLeft == 6'd0) begin
                    nextState = ST_DONE;
                end else if (!rxByteValid && gapCnt == GAP_LAST) begin
                    timeout   = 1'b1;
                    nextState = ST_IDLE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opReg     <= '0;
            dataReg   <= '0;
            wordsLeft <= '0;
            byteCnt   <= '0;
            wordShift <= '0;
            gapCnt    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    byteCnt <= '0;
                    gapCnt  <= '0;
                    if (cmd_valid) begin
                        opReg     <= cmd_op;
                        dataReg   <= cmd_data;
                        wordsLeft <= cmd_rsp_words;
                    end
                end
                ST_SEND_OP, ST_SEND_DATA: begin
                    gapCnt <= '0;
                    if (txStart) begin
                        byteCnt <= (state == ST_SEND_OP) ? 3'd1 : byteCnt + 3'd1;
                    end else if (nextState == ST_RECV) begin
                        byteCnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (rxByteValid && wordsLeft != 6'd0) begin
                        gapCnt <= '0;
                        if (byteCnt == 3'd3) begin
                            rsp_data  <= {rxByte, wordShift};
                            rsp_valid <= 1'b1;
                            rsp_last  <= (wordsLeft == 6'd1);
                            wordsLeft <= wordsLeft - 6'd1;
                            byteCnt   <= '0;
                        end else begin
                            wordShift <= {rxByte, wordShift[23:8]};
                            byteCnt   <= byteCnt + 3'd1;
                        end
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_host_link.sv
// Randomised bench for debug_host_link with a UART model of the debug unit.
module tb_debug_host_link;

    localparam int unsigned CPB      = 4;
    localparam int unsigned TMO      = 200;
    localparam int          BYTE_CYC = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_op = '0;
    logic [31:0] cmd_data = '0;
    logic [5:0]  cmd_rsp_words = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        done;
    logic        timeout;
    logic        frame_err;
    logic        busy;
    logic        TX;
    logic        RX = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    debug_host_link #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_rsp_words (cmd_rsp_words),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .done          (done),
        .timeout       (timeout),
        .frame_err     (frame_err),
        .busy          (busy),
        .TX            (TX),
        .RX            (RX)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed traffic, collected on the falling edge.
    logic [7:0]  txBytes[$];
    int          txCycs[$];
    logic [32:0] rspWords[$];
    int          rspCycs[$];
    int          doneCycs[$];
    int          tmoCycs[$];
    int          ferrCount = 0;
    logic [7:0]  replyQ[$];

    bit         decActive = 0;
    int         decPos = 0;
    int         decStart = 0;
    logic [7:0] decByte = '0;

    always @(negedge clk) begin
        if (rst) begin
            decActive = 0;
        end else begin
            if (rsp_valid) begin
                rspWords.push_back({rsp_last, rsp_data});
                rspCycs.push_back(cyc);
            end
            if (done) doneCycs.push_back(cyc);
            if (timeout) tmoCycs.push_back(cyc);
            if (frame_err) ferrCount++;
            if (!decActive) begin
                if (TX == 1'b0) begin
                    decActive = 1;
                    decPos    = 0;
                    decStart  = cyc;
                end
            end else begin
                decPos++;
                if (decPos % CPB == CPB / 2) begin
                    if (decPos / CPB == 0) begin
                        checkVal("txStartBit", TX, 1'b0);
                    end else if (decPos / CPB <= 8) begin
                        decByte[decPos / CPB - 1] = TX;
                    end else begin
                        checkVal("txStopBit", TX, 1'b1);
                        txBytes.push_back(decByte);
                        txCycs.push_back(decStart);
                    end
                end
                if (decPos == BYTE_CYC - 1) decActive = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearObs();
        txBytes.delete();
        txCycs.delete();
        rspWords.delete();
        rspCycs.delete();
        doneCycs.delete();
        tmoCycs.delete();
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] data, input int words,
                         input int holdExtra, output int acceptCyc);
        int w;
        w = 0;
        while (!cmd_ready && w < 2000) begin
            tick(1);
            w++;
        end
        checkVal("readyBeforeCmd", cmd_ready, 1'b1);
        cmd_op        = op;
        cmd_data      = data;
        cmd_rsp_words = 6'(words);
        cmd_valid     = 1'b1;
        tick(1);
        acceptCyc = cyc;
        checkVal("busyAfterAccept", busy, 1'b1);
        repeat (holdExtra) begin
            cmd_op        = 8'($urandom);
            cmd_data      = $urandom;
            cmd_rsp_words = 6'($urandom);
            tick(1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic sendRxByte(input logic [7:0] b, input logic stopBit);
        logic [9:0] f;
        f = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            tick(CPB);
        end
        RX = 1'b1;
    endtask

    task automatic waitTx(input int n, input int limit);
        int w;
        w = 0;
        while (txBytes.size() < n && w < limit) begin
            tick(1);
            w++;
        end
    endtask

    task automatic waitEnd(input int limit);
        int w;
        w = 0;
        while (doneCycs.size() == 0 && tmoCycs.size() == 0 && w < limit) begin
            tick(1);
            w++;
        end
    endtask

    // Full transaction against the reference model; replyQ supplies 4*words bytes.
    task automatic runTxn(input logic [7:0] op, input logic [31:0] data, input int words,
                          input int holdExtra, input string tag);
        logic [7:0]  expTx[$];
        logic [32:0] expRsp[$];
        int acc;
        expTx.delete();
        expRsp.delete();
        expTx.push_back(op);
        if (op[7]) begin
            for (int i = 0; i < 4; i++) expTx.push_back(8'(data >> (8 * i)));
        end
        for (int wd = 0; wd < words; wd++) begin
            expRsp.push_back({(wd == words - 1) ? 1'b1 : 1'b0,
                              replyQ[4*wd+3], replyQ[4*wd+2], replyQ[4*wd+1], replyQ[4*wd]});
        end
        clearObs();
        issue(op, data, words, holdExtra, acc);
        waitTx(expTx.size(), expTx.size() * BYTE_CYC + 100);
        checkVal({tag, ".txCount"}, txBytes.size(), expTx.size());
        for (int i = 0; i < expTx.size(); i++) begin
            if (i < txBytes.size()) begin
                checkVal({tag, ".txByte"}, txBytes[i], expTx[i]);
                checkVal({tag, ".txStartCyc"}, txCycs[i], acc + 1 + i * BYTE_CYC);
            end
        end
        for (int i = 0; i < 4 * words; i++) begin
            sendRxByte(replyQ[i], 1'b1);
            tick($urandom_range(0, 20));
        end
        waitEnd(words * 4 * (BYTE_CYC + 30) + 500);
        checkVal({tag, ".doneCount"}, doneCycs.size(), 1);
        checkVal({tag, ".tmoCount"}, tmoCycs.size(), 0);
        checkVal({tag, ".rspCount"}, rspWords.size(), expRsp.size());
        for (int i = 0; i < expRsp.size(); i++) begin
            if (i < rspWords.size()) checkVal({tag, ".rspWord"}, rspWords[i], expRsp[i]);
        end
        if (doneCycs.size() > 0) begin
            if (words == 0)
                checkVal({tag, ".doneCyc"}, doneCycs[0], acc + 1 + expTx.size() * BYTE_CYC);
            else if (rspCycs.size() > 0)
                checkVal({tag, ".doneAfterLast"}, doneCycs[0], rspCycs[rspCycs.size()-1] + 1);
        end
        tick(1);
        checkVal({tag, ".readyAfter"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int acc;
        int ret;
        int f0;
        logic [7:0] op;
        int words;

        // 1: reset
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkVal("rst.TX", TX, 1'b1);
        end
        checkVal("rst.cmdReady", cmd_ready, 1'b1);
        checkVal("rst.busy", busy, 1'b0);
        checkVal("rst.rspValid", rsp_valid, 1'b0);
        checkVal("rst.rspLast", rsp_last, 1'b0);
        checkVal("rst.done", done, 1'b0);
        checkVal("rst.timeout", timeout, 1'b0);
        checkVal("rst.frameErr", frame_err, 1'b0);
        checkVal("rst.rspData", rsp_data, 32'h0);
        rst = 1'b0;
        tick(2);

        // 2: opcode only, no response
        replyQ.delete();
        runTxn(8'h05, 32'h0, 0, 0, "opOnly");
        if (txBytes.size() > 0) checkVal("opOnly.byte05", txBytes[0], 8'h05);

        // 3: opcode with payload
        runTxn(8'h81, 32'hDEADBEEF, 0, 2, "payload");
        if (txBytes.size() == 5) checkVal("payload.lastByte", txBytes[4], 8'hDE);

        // 4: two response words
        replyQ = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
        runTxn(8'h02, 32'h0, 2, 0, "twoWords");
        if (rspWords.size() == 2) begin
            checkVal("twoWords.w0", rspWords[0], {1'b0, 32'h12345678});
            checkVal("twoWords.w1", rspWords[1], {1'b1, 32'h9ABCDEF0});
        end

        // 5: response gap timeout
        clearObs();
        issue(8'h03, 32'h0, 1, 0, acc);
        waitTx(1, BYTE_CYC + 100);
        sendRxByte(8'hA1, 1'b1);
        sendRxByte(8'hB2, 1'b1);
        ret = cyc;
        waitEnd(TMO + 200);
        checkVal("tmo.count", tmoCycs.size(), 1);
        checkVal("tmo.noDone", doneCycs.size(), 0);
        checkVal("tmo.noRsp", rspWords.size(), 0);
        if (tmoCycs.size() > 0)
            checkVal("tmo.window", (tmoCycs[0] >= ret + 196) && (tmoCycs[0] <= ret + 206), 1'b1);
        tick(1);
        checkVal("tmo.readyAfter", cmd_ready, 1'b1);

        // 6a: bad stop bit is flagged and not counted
        clearObs();
        f0 = ferrCount;
        issue(8'h01, 32'h0, 1, 0, acc);
        waitTx(1, BYTE_CYC + 100);
        sendRxByte(8'h11, 1'b1);
        sendRxByte(8'h5A, 1'b0);
        tick(2 * CPB);
        sendRxByte(8'h22, 1'b1);
        sendRxByte(8'h33, 1'b1);
        sendRxByte(8'h44, 1'b1);
        waitEnd(500);
        checkVal("ferr.pulses", ferrCount - f0, 1);
        checkVal("ferr.rspCount", rspWords.size(), 1);
        if (rspWords.size() > 0) checkVal("ferr.word", rspWords[0], {1'b1, 32'h44332211});
        checkVal("ferr.done", doneCycs.size(), 1);
        tick(2);

        // 6b: reset in the middle of the payload
        clearObs();
        issue(8'h81, 32'h01234567, 0, 0, acc);
        tick(60);
        rst = 1'b1;
        tick(1);
        checkVal("midRst.TX", TX, 1'b1);
        checkVal("midRst.ready", cmd_ready, 1'b1);
        checkVal("midRst.busy", busy, 1'b0);
        tick(1);
        rst = 1'b0;
        checkVal("midRst.noDone", doneCycs.size(), 0);
        checkVal("midRst.noTmo", tmoCycs.size(), 0);
        runTxn(8'h05, 32'h0, 0, 0, "afterRst");

        // Randomised transactions
        for (int t = 0; t < 20; t++) begin
            op    = 8'($urandom);
            words = $urandom_range(0, 3);
            replyQ.delete();
            for (int i = 0; i < 4 * words; i++) replyQ.push_back(8'($urandom));
            runTxn(op, $urandom, words, $urandom_range(0, 5), "rand");
            tick($urandom_range(0, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
